ps2_host_tx: RTL



---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_line_sync.sv | 31 +++
 rtl/ps2_host_tx.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, register offsets
// and default line timing for a 50 MHz system clock.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_t;

  localparam logic [7:0] TX_DATA_OFS = 8'd0;
  localparam logic [7:0] STATUS_OFS  = 8'd1;

  localparam int DEF_INHIBIT_CYCLES = 5000;
  localparam int DEF_REQ_CYCLES     = 50;
  localparam int DEF_TIMEOUT_CYCLES = 750000;

  // PS/2 frames carry odd parity over the eight data bits
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one PS/2 line with a falling-edge pulse taken
// one cycle after the second flop. Lines idle high, so flops reset to 1.
module ps2_line_sync (
  input  logic CLK,
  input  logic RESETN,
  input  logic line_in,
  output logic line_s,
  output logic fall
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  // Stage 0/1: metastability flops; stage 2: previous level for edge detect
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      prev_p2 <= 1'b1;
    end else begin
      sync_p0 <= line_in;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign line_s = sync_p1;
  assign fall   = prev_p2 & ~sync_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// Bus-mapped PS/2 host-to-device transmitter: inhibit, request-to-send,
// clocked-out frame, device ack, with timeout and a level completion interrupt.
module ps2_host_tx import ps2_pkg::*; #(
  parameter logic [7:0] BASE_ADDR      = 8'hC0,
  parameter int         INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int         REQ_CYCLES     = DEF_REQ_CYCLES,
  parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       CLK,
  input  logic       RESETN,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE,
  output logic       SEND_INTERRUPT,
  input  logic       INTERRUPT_ACK,
  output logic       BUSY
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES);
  localparam int REQ_W = $clog2(REQ_CYCLES);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [REQ_W-1:0] REQ_LAST = REQ_W'(REQ_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] TX_ADDR = BASE_ADDR + TX_DATA_OFS;
  localparam logic [7:0] ST_ADDR = BASE_ADDR + STATUS_OFS;

  logic clk_s;
  logic clk_fall;
  logic data_s;
  logic unused_data_fall;

  ps2_line_sync u_clk_sync (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .line_in (PS2_CLK_IN),
    .line_s  (clk_s),
    .fall    (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .line_in (PS2_DATA_IN),
    .line_s  (data_s),
    .fall    (unused_data_fall)
  );

  ps2_tx_state_t    state;
  logic [INH_W-1:0] inh_cnt;
  logic [REQ_W-1:0] req_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [3:0]       edge_cnt;
  logic [8:0]       frame_q;
  logic             nack_q;
  logic             timeout_q;
  logic             overrun_q;
  logic             rd_vld_p1;
  logic [7:0]       status_p1;

  logic wr_tx;
  logic rd_st;
  logic to_hit;
  logic idle_hit;
  logic done;

  assign wr_tx    = BUS_WE && (BUS_ADDR == TX_ADDR);
  assign rd_st    = !BUS_WE && (BUS_ADDR == ST_ADDR);
  assign to_hit   = (state inside {ST_SEND, ST_ACK, ST_WAIT_IDLE}) && (to_cnt == TO_LAST);
  assign idle_hit = (state == ST_WAIT_IDLE) && clk_s && data_s;
  assign done     = to_hit || idle_hit;

  // Byte and parity captured on the accepting write; consumed bit by bit in SEND
  always_ff @(posedge CLK) begin
    if (state == ST_IDLE && wr_tx) begin
      frame_q <= {odd_parity(BUS_DATA), BUS_DATA};
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state          <= ST_IDLE;
      inh_cnt        <= '0;
      req_cnt        <= '0;
      to_cnt         <= '0;
      edge_cnt       <= '0;
      nack_q         <= 1'b0;
      timeout_q      <= 1'b0;
      overrun_q      <= 1'b0;
      BUSY           <= 1'b0;
      SEND_INTERRUPT <= 1'b0;
      PS2_CLK_OE     <= 1'b0;
      PS2_DATA_OE    <= 1'b0;
    end else begin
      if (done) begin
        SEND_INTERRUPT <= 1'b1;
      end else if (INTERRUPT_ACK) begin
        SEND_INTERRUPT <= 1'b0;
      end

      if (state inside {ST_REQ, ST_SEND, ST_ACK, ST_WAIT_IDLE}) begin
        to_cnt <= to_cnt + 1'b1;
      end

      unique case (state)
        ST_IDLE: begin
          if (wr_tx) begin
            state      <= ST_INHIBIT;
            PS2_CLK_OE <= 1'b1;
            BUSY       <= 1'b1;
            nack_q     <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
            inh_cnt    <= '0;
          end
        end
        ST_INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            state       <= ST_REQ;
            PS2_DATA_OE <= 1'b1;
            req_cnt     <= '0;
            to_cnt      <= '0;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end
        ST_REQ: begin
          if (req_cnt == REQ_LAST) begin
            state      <= ST_SEND;
            PS2_CLK_OE <= 1'b0;
            edge_cnt   <= '0;
          end else begin
            req_cnt <= req_cnt + 1'b1;
          end
        end
        ST_SEND: begin
          // Edges 1..9 put out data[0..7] then parity; edge 10 releases for stop
          if (clk_fall) begin
            edge_cnt <= edge_cnt + 1'b1;
            if (edge_cnt == 4'd9) begin
              PS2_DATA_OE <= 1'b0;
              state       <= ST_ACK;
            end else begin
              PS2_DATA_OE <= ~frame_q[edge_cnt];
            end
          end
        end
        ST_ACK: begin
          if (clk_fall) begin
            nack_q <= data_s;
            state  <= ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (clk_s && data_s) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (to_hit) begin
        PS2_CLK_OE  <= 1'b0;
        PS2_DATA_OE <= 1'b0;
        timeout_q   <= 1'b1;
        BUSY        <= 1'b0;
        state       <= ST_IDLE;
      end

      if (wr_tx && state != ST_IDLE) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Read stage: status is captured, then driven onto the bus for one cycle
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      rd_vld_p1 <= 1'b0;
      status_p1 <= '0;
    end else begin
      rd_vld_p1 <= rd_st;
      status_p1 <= {4'b0000, overrun_q, timeout_q, nack_q, BUSY};
    end
  end

  assign BUS_DATA = rd_vld_p1 ? status_p1 : 8'hzz;

endmodule
